// File: rtl/udp_tx_sched.sv
// Round-robin frame scheduler: shares one FIFO-to-MAC streamer between CH frame
// FIFOs, runs the fs/fd handshake and steers the streamer read port to the winner.
module udp_tx_sched #(
  parameter int unsigned CH      = 4,
  parameter int unsigned MAX_LEN = 1472,
  parameter int unsigned GAP     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    ch_ready,
  input  logic [12*CH-1:0] ch_len,
  output logic [CH-1:0]    ch_rxen,
  input  logic [8*CH-1:0]  ch_rxd,
  output logic [CH-1:0]    ch_done,
  output logic [CH-1:0]    ch_err,
  output logic             fs,
  input  logic             fd,
  output logic [11:0]      data_len,
  input  logic             fifod_rxen,
  output logic [7:0]       fifod_rxd,
  output logic             busy,
  output logic [2:0]       cur_ch
);
  localparam int unsigned LEN_W = 12;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned LANES = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_GAP} state_t;

  state_t           state;
  state_t           state_next;
  logic [LANES-1:0] ready8;
  logic [LANES-1:0] legal;
  logic [LANES-1:0] elig;
  logic [LEN_W-1:0] len_a [LANES];
  logic [7:0]       rxd_a [LANES];
  logic [2:0]       last;
  logic [2:0]       grant;
  logic             grant_vld;
  logic [CNT_W-1:0] gap_cnt;
  logic             gap_done;

  // Lanes padded to 8 so any 3-bit channel index stays in range.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i < CH) begin : g_used
      assign len_a[i]  = ch_len[LEN_W*i +: LEN_W];
      assign rxd_a[i]  = ch_rxd[8*i +: 8];
      assign ready8[i] = ch_ready[i];
      assign legal[i]  = (len_a[i] != '0) && (len_a[i] <= LEN_W'(MAX_LEN));
    end else begin : g_unused
      assign len_a[i]  = '0;
      assign rxd_a[i]  = '0;
      assign ready8[i] = 1'b0;
      assign legal[i]  = 1'b0;
    end
  end

  assign elig     = ready8 & legal;
  assign gap_done = (gap_cnt == CNT_W'(GAP - 1));

  // First eligible channel after the last grant, wrapping modulo CH.
  always_comb begin
    logic [3:0] idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = '0;
    for (int k = 1; k <= int'(CH); k++) begin
      idx = 4'(last) + 4'(k);
      if (idx >= 4'(CH)) idx = idx - 4'(CH);
      if (!grant_vld && elig[idx[2:0]]) begin
        grant_vld = 1'b1;
        grant     = idx[2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (grant_vld) state_next = S_RUN;
      S_RUN:   if (fd) state_next = S_FIN;
      S_FIN:   if (!fd) state_next = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Read strobe and done pulse are steered combinationally to the granted lane.
  always_comb begin
    ch_rxen = '0;
    ch_done = '0;
    fs      = (state == S_RUN);
    busy    = (state != S_IDLE);
    for (int i = 0; i < int'(CH); i++) begin
      if (3'(i) == cur_ch) begin
        ch_rxen[i] = (state == S_RUN) && fifod_rxen;
        ch_done[i] = (state == S_FIN) && !fd;
      end
    end
  end

  assign fifod_rxd = rxd_a[cur_ch];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch   <= '0;
      last     <= 3'(CH - 1);
      data_len <= '0;
      gap_cnt  <= '0;
      ch_err   <= '0;
    end else begin
      ch_err <= ch_ready & ~legal[CH-1:0];
      if (state == S_IDLE && grant_vld) begin
        cur_ch   <= grant;
        last     <= grant;
        data_len <= len_a[grant];
      end
      if (state == S_GAP) gap_cnt <= gap_cnt + CNT_W'(1);
      else                gap_cnt <= '0;
    end
  end

endmodule
